lsd_scheduler: RTL and testbench
================================

# lsd_scheduler

- Shares one leading-sign-detect (LSD) datapath among `n_req` requesters: a round-robin arbiter picks one operand per cycle.
- A two-stage pipeline computes the leading-sign count and the normalised operand, then returns the result tagged with the requester ID under a valid/ready handshake.
- Sits between the fixed-point producers and the shared normalisation resource of the arithmetic library.

## Interface
- `width`, 16, operand word width, ≥ 4.
- `n_req`, 4, number of requesters, ≥ 2.
- `speed`, 0, performance setting passed to the LSD prefix structure (0 serial, 1 Brent-Kung, 2 Sklansky).
- `clk_i` input 1: clock, all state on rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_valid_i` input n_req: per-requester operand valid.
- `req_data_i` input n_req*width: operands, requester r in bits [r*width +: width].
- `req_ready_o` output n_req: one-hot grant; handshake completes when valid and ready.
- `res_valid_o` output 1: result valid.
- `res_ready_i` input 1: result consumer ready.
- `res_id_o` output clog2(n_req): requester index of the result.
- `res_lsc_o` output clog2(width): redundant leading-sign count.
- `res_all_o` output 1: every bit equals the sign.
- `res_norm_o` output width: operand shifted left by `res_lsc_o`.

## Operation
- **Arbitration.**
  - Round-robin with pointer `rr_q`; priority starts at `rr_q` and wraps modulo `n_req`.
  - `req_ready_o[g]` is asserted only for the winner `g`, and only when stage 0 can accept.
  - Stage 0 can accept when it is empty, or when it is emptying into stage 1 this cycle.
  - On an accepted handshake, `rr_q` becomes (g+1) mod n_req. Otherwise `rr_q` holds.
  - `req_ready_o` may depend combinationally on `req_valid_i`. A requester must hold its data while valid and not granted.
- **Stage 0 (capture).** Registers the operand, `g` and valid flag `v0_q`.
- **Stage 1 (compute).**
  - Runs the LSD on the stage-0 operand. `pos` = index of the highest bit below the MSB that differs from the MSB.
  - If such a bit exists: `res_lsc_o` = width-2-pos and `res_all_o` = 0.
  - Otherwise: `res_lsc_o` = width-1 and `res_all_o` = 1.
  - `res_norm_o` = operand << `res_lsc_o`, truncated to `width` bits.
  - All values are registered together with the ID and `v1_q`.
- **Flow control.**
  - Stage 1 loads when empty or when `res_valid_o` and `res_ready_i` are both high.
  - Stage 0 advances under the same condition.
  - Both stages stall and hold their data otherwise.
  - Full throughput is one result per cycle with `res_ready_i` held high.
- **Reset.**
  - Effective at any time, including mid-operation. In-flight operands are discarded, not completed.
  - `v0_q` = `v1_q` = 0 and `rr_q` = 0.
  - `res_valid_o` = 0, `res_id_o` = 0, `res_lsc_o` = 0, `res_all_o` = 0, `res_norm_o` = 0.
  - `req_ready_o` = all zeros while `rst_ni` is low.

## Timing
- Latency: a handshake accepted at edge N produces `res_valid_o` after edge N+1 (2 registers), provided there is no stall.
- `res_*` outputs are registered and stay stable while `res_valid_o` = 1 and `res_ready_i` = 0.
- Simultaneous result drain and new grant in the same cycle is legal. There are no bubbles with `res_ready_i` held at 1.
- Capacity is 2 operands in flight. With `res_ready_i` = 0, after two accepts `req_ready_o` stays at 0 until the drain.

## Configuration
- `LSD_SCHED_NORM_EN` defined:
  - The barrel shifter is built.
  - `res_norm_o` is as specified above.
- `LSD_SCHED_NORM_EN` undefined:
  - No shifter is built; `res_norm_o` is tied to 0.
  - Count, flag, ID and handshake behaviour are identical to the defined case.

## Structure
- Package `lsd_sched_pkg` holds:
  - `id_t` (clog2(n_req) bits), `lsc_t` (clog2(width) bits);
  - the stage payload struct (data, id, valid);
  - function `lsc_from_onehot` (one-hot position → count).
- Sub-module `lsd_rr_arbiter`: round-robin grant plus pointer register.
- The LSD itself reuses the library's `LeadSignDet` (parameters `width`, `speed`) followed by one-hot encoding.

## Test plan
All tests use width=8, n_req=4.
- **Single request.** Requester 1 sends 8'b00000101 → 2 cycles later `res_valid_o` = 1, id = 1, lsc = 4, all = 0, norm = 8'b01010000.
- **Negative and edge operands.**
  - 8'hFA → lsc = 4, norm = 8'hA0.
  - 8'h00 → lsc = 7, all = 1, norm = 8'h00.
  - 8'h40 → lsc = 0, norm = 8'h40.
- **Fairness.** All 4 requesters valid continuously with `res_ready_i` = 1 → grants 0,1,2,3,0,... and one result per cycle with matching IDs.
- **Backpressure.** `res_ready_i` = 0 → exactly 2 accepts, then `req_ready_o` = 0 and outputs frozen. Releasing it drains the results in order with none lost.
- **Reset mid-operation.** Assert `rst_ni` low with both stages full → all outputs 0 immediately and no stale result after release. The first grant after release goes to requester 0.
- **Macro off.** Rerun the single-request test without `LSD_SCHED_NORM_EN` → identical id/lsc/all, `res_norm_o` = 0.

Source files
------------

// File: rtl/lsd_sched_pkg.sv
// Shared types and helpers for the lsd_scheduler slice.
// Types are sized to the largest supported configuration; users slice them down.
package lsd_sched_pkg;

    localparam int unsigned DATA_W_MAX = 64;
    localparam int unsigned ID_W_MAX   = 8;
    localparam int unsigned LSC_W_MAX  = 8;

    typedef logic [ID_W_MAX-1:0]  id_t;
    typedef logic [LSC_W_MAX-1:0] lsc_t;

    typedef struct packed {
        logic [DATA_W_MAX-1:0] data;
        id_t                   id;
        logic                  valid;
    } stage_t;

    // One-hot position of the first differing bit below the MSB -> redundant sign count.
    // An all-zero vector means every bit equals the sign: count is w-1.
    function automatic lsc_t lsc_from_onehot(input logic [DATA_W_MAX-1:0] onehot,
                                             input int unsigned           w);
        lsc_t cnt;
        cnt = lsc_t'(w - 1);
        for (int unsigned i = 0; i < DATA_W_MAX; i++) begin
            if ((i + 1 < w) && onehot[i]) begin
                cnt = lsc_t'(w - 2 - i);
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/LeadSignDet.sv
// Leading-sign detector: one-hot marker of the highest bit below the MSB that differs from the MSB.
// speed selects a serial (0) or log-depth (1, 2) prefix-OR structure; the function is identical.
module LeadSignDet #(
    parameter int unsigned width = 16,
    parameter int unsigned speed = 0
) (
    input  logic [width-1:0] data_i,
    output logic [width-1:0] onehot_o
);

    logic [width-2:0] diff;
    logic [width-2:0] above;

    assign diff = data_i[width-2:0] ^ {(width-1){data_i[width-1]}};

    generate
        if (speed == 0) begin : g_serial
            always_comb begin
                above[width-2] = 1'b0;
                for (int unsigned i = width - 2; i > 0; i--) begin
                    above[i-1] = above[i] | diff[i];
                end
            end
        end else begin : g_parallel
            logic [width-2:0] incl;
            always_comb begin
                incl = diff;
                // Ascending i reads incl[i+d] before it is updated at this level.
                for (int unsigned d = 1; d < width - 1; d = d * 2) begin
                    for (int unsigned i = 0; i + d < width - 1; i++) begin
                        incl[i] = incl[i] | incl[i+d];
                    end
                end
                above = {1'b0, incl[width-2:1]};
            end
        end
    endgenerate

    assign onehot_o = {1'b0, diff & ~above};

endmodule

// File: rtl/lsd_rr_arbiter.sv
// Round-robin arbiter: priority starts at rr_q and wraps; pointer moves past the winner on a grant.
module lsd_rr_arbiter #(
    parameter  int unsigned n_req = 4,
    localparam int unsigned IDW   = $clog2(n_req)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [n_req-1:0] valid_i,
    input  logic             enable_i,
    output logic [n_req-1:0] grant_o,
    output logic [IDW-1:0]   grant_id_o
);

    logic [IDW-1:0] rr_q, rr_d;
    logic           found;
    int unsigned    cand;

    always_comb begin
        found      = 1'b0;
        grant_id_o = '0;
        cand       = 0;
        for (int unsigned i = 0; i < n_req; i++) begin
            cand = (i + 32'(rr_q)) % n_req;
            if (!found && valid_i[cand]) begin
                found      = 1'b1;
                grant_id_o = IDW'(cand);
            end
        end
        grant_o = '0;
        if (found && enable_i && rst_ni) begin
            grant_o[grant_id_o] = 1'b1;
        end
        rr_d = rr_q;
        if (|grant_o) begin
            rr_d = (grant_id_o == IDW'(n_req - 1)) ? '0 : grant_id_o + IDW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/lsd_scheduler.sv
// Shares one LSD datapath among n_req requesters: RR grant, capture stage, compute stage.
// Define LSD_SCHED_NORM_EN to build the normalising shifter; otherwise res_norm_o is 0.
module lsd_scheduler
    import lsd_sched_pkg::*;
#(
    parameter  int unsigned width = 16,
    parameter  int unsigned n_req = 4,
    parameter  int unsigned speed = 0,
    localparam int unsigned IDW   = $clog2(n_req),
    localparam int unsigned LSCW  = $clog2(width)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [n_req-1:0]       req_valid_i,
    input  logic [n_req*width-1:0] req_data_i,
    output logic [n_req-1:0]       req_ready_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [IDW-1:0]         res_id_o,
    output logic [LSCW-1:0]        res_lsc_o,
    output logic                   res_all_o,
    output logic [width-1:0]       res_norm_o
);

    stage_t            s0_q, s0_d;
    logic              load1;
    logic              accept0;
    logic [n_req-1:0]  grant;
    logic [IDW-1:0]    grant_id;

    logic [width-1:0]  op;
    logic [width-1:0]  onehot;
    logic [LSCW-1:0]   lsc_d;
    logic              all_d;

    logic              v1_q;
    logic [IDW-1:0]    id1_q;
    logic [LSCW-1:0]   lsc1_q;
    logic              all1_q;

    // Stage 0 may refill in the same cycle it hands its operand to stage 1.
    assign load1   = !v1_q || res_ready_i;
    assign accept0 = !s0_q.valid || load1;

    lsd_rr_arbiter #(
        .n_req (n_req)
    ) u_arb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (req_valid_i),
        .enable_i   (accept0),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign req_ready_o = grant;

    always_comb begin
        s0_d = s0_q;
        if (accept0) begin
            s0_d.valid = |grant;
            s0_d.id    = id_t'(grant_id);
            s0_d.data  = DATA_W_MAX'(req_data_i[grant_id*width +: width]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_q <= '0;
        end else begin
            s0_q <= s0_d;
        end
    end

    assign op = s0_q.data[width-1:0];

    LeadSignDet #(
        .width (width),
        .speed (speed)
    ) u_lsd (
        .data_i   (op),
        .onehot_o (onehot)
    );

    assign lsc_d = LSCW'(lsc_from_onehot(DATA_W_MAX'(onehot), width));
    assign all_d = ~|onehot;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q   <= 1'b0;
            id1_q  <= '0;
            lsc1_q <= '0;
            all1_q <= 1'b0;
        end else if (load1) begin
            v1_q <= s0_q.valid;
            if (s0_q.valid) begin
                id1_q  <= s0_q.id[IDW-1:0];
                lsc1_q <= lsc_d;
                all1_q <= all_d;
            end
        end
    end

`ifdef LSD_SCHED_NORM_EN
    logic [width-1:0] norm_d, norm1_q;

    assign norm_d = op << lsc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            norm1_q <= '0;
        end else if (load1 && s0_q.valid) begin
            norm1_q <= norm_d;
        end
    end

    assign res_norm_o = norm1_q;
`else
    assign res_norm_o = '0;
`endif

    assign res_valid_o = v1_q;
    assign res_id_o    = id1_q;
    assign res_lsc_o   = lsc1_q;
    assign res_all_o   = all1_q;

endmodule

// File: tb/tb_lsd_scheduler.sv
// Self-checking bench for lsd_scheduler (width=8, n_req=4) against a queue-based reference model.
module tb_lsd_scheduler;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LSCW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   vld;
    logic [N*W-1:0] dat;
    logic [N-1:0]   rdy;
    logic           res_valid;
    logic           res_ready;
    logic [IDW-1:0] res_id;
    logic [LSCW-1:0] res_lsc;
    logic           res_all;
    logic [W-1:0]   res_norm;

    always #5 clk = ~clk;

    lsd_scheduler #(
        .width (W),
        .n_req (N),
        .speed (0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (vld),
        .req_data_i  (dat),
        .req_ready_o (rdy),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_id_o    (res_id),
        .res_lsc_o   (res_lsc),
        .res_all_o   (res_all),
        .res_norm_o  (res_norm)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         id;
        logic [W-1:0] d;
        int         age;
    } item_t;

    item_t q[$];
    int    rr = 0;
    int    mode = 0;
    int    last_grant = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_lsc(input logic [W-1:0] x);
        for (int p = W - 2; p >= 0; p--) begin
            if (x[p] != x[W-1]) return W - 2 - p;
        end
        return W - 1;
    endfunction

    function automatic logic [W-1:0] ref_norm(input logic [W-1:0] x);
`ifdef LSD_SCHED_NORM_EN
        return x << ref_lsc(x);
`else
        return '0;
`endif
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic int exp_winner();
        for (int i = 0; i < N; i++) begin
            if (vld[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    // One clock: compare at negedge, advance model at posedge, then refresh stimulus.
    task automatic step();
        int           w;
        logic         hv, drain, acc_en;
        logic [N-1:0] er;
        @(negedge clk);
        hv     = (q.size() > 0) && (q[0].age >= 1);
        drain  = hv && res_ready;
        acc_en = (q.size() < 2) || drain;
        w      = exp_winner();
        er     = '0;
        if (acc_en && w >= 0) er[w] = 1'b1;
        chk("ready", 32'(rdy), 32'(er));
        chk("res_valid", 32'(res_valid), 32'(hv));
        if (hv) begin
            chk("res_id", 32'(res_id), 32'(q[0].id));
            chk("res_lsc", 32'(res_lsc), 32'(ref_lsc(q[0].d)));
            chk("res_all", 32'(res_all), 32'(ref_lsc(q[0].d) == W - 1));
            chk("res_norm", 32'(res_norm), 32'(ref_norm(q[0].d)));
        end
        @(posedge clk);
        if (drain) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        last_grant = -1;
        if (er != '0) begin
            q.push_back('{id: w, d: dat[w*W +: W], age: 0});
            rr = (w + 1) % N;
            last_grant = w;
        end
        #1;
        if (mode == 1) res_ready = ($urandom_range(0, 3) != 0);
        for (int r = 0; r < N; r++) begin
            if (r == last_grant) begin
                if (mode == 0) vld[r] = 1'b0;
                else begin
                    dat[r*W +: W] = rand_op();
                    if (mode == 1) vld[r] = 1'($urandom_range(0, 1));
                end
            end else if (!vld[r] && mode != 0) begin
                vld[r] = (mode == 2) || ($urandom_range(0, 2) == 0);
                dat[r*W +: W] = rand_op();
            end
        end
    endtask

    task automatic directed(input int r, input logic [W-1:0] d, input int elsc,
                            input logic eall, input logic [W-1:0] enorm);
        vld[r] = 1'b1;
        dat[r*W +: W] = d;
        #1;
        chk("dir_ready", 32'(rdy), 32'(1 << r));
        step();
        chk("dir_latency", 32'(res_valid), 32'd0);
        step();
        chk("dir_valid", 32'(res_valid), 32'd1);
        chk("dir_id", 32'(res_id), 32'(r));
        chk("dir_lsc", 32'(res_lsc), 32'(elsc));
        chk("dir_all", 32'(res_all), 32'(eall));
`ifdef LSD_SCHED_NORM_EN
        chk("dir_norm", 32'(res_norm), 32'(enorm));
`else
        chk("dir_norm", 32'(res_norm), 32'(0 & enorm));
`endif
        step();
    endtask

    initial begin
        int gseq[8];
        int acc;

        vld = '1;
        dat = 32'($urandom);
        res_ready = 1'b0;
        #12;
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_outs", {res_id, res_lsc, res_all, res_norm}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vld = '0;
        res_ready = 1'b1;

        mode = 0;
        directed(1, 8'b0000_0101, 4, 1'b0, 8'b0101_0000);
        directed(2, 8'hFA, 4, 1'b0, 8'hA0);
        directed(0, 8'h00, 7, 1'b1, 8'h00);
        directed(3, 8'h40, 0, 1'b0, 8'h40);

        mode = 2;
        vld = '1;
        for (int r = 0; r < N; r++) dat[r*W +: W] = rand_op();
        for (int i = 0; i < 8; i++) begin
            step();
            gseq[i] = last_grant;
        end
        for (int i = 0; i < 8; i++) chk("fair_grant", 32'(gseq[i]), 32'(i % N));
        chk("fair_no_bubble", 32'(res_valid), 32'd1);

        mode = 0;
        vld = '0;
        for (int i = 0; i < 3; i++) step();
        res_ready = 1'b0;
        mode = 2;
        vld = '1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_grant >= 0) acc++;
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_ready", 32'(rdy), 32'd0);
        chk("bp_head_valid", 32'(res_valid), 32'd1);
        chk("bp_head_id", 32'(res_id), 32'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rdy), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_outs", {res_id, res_lsc, res_all, res_norm}, 32'd0);
        q.delete();
        rr = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(rdy), 32'b0001);
        chk("post_rst_valid", 32'(res_valid), 32'd0);
        for (int i = 0; i < 6; i++) step();

        mode = 1;
        for (int i = 0; i < 600; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
